spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- SPI peripheral (mode 0) that turns serial frames from an external SPI controller into register-bus transactions.
- Drives the register bus as initiator (addr/wdat/wr/rd out, rdat/ack in); the register file is the responder.
- Sits between the chip's SPI pins and the motor-controller register block.
- Single clock domain; SPI pins are asynchronous and oversampled.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 16, register data width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sclk  input  1  SPI clock, async, idle low
- cs  input  1  SPI chip select, active low, async
- mosi  input  1  SPI data in, async
- miso  output  1  SPI data out, registered
- addr  output  ADDR_W  register address
- wdat  output  DATA_W  write data
- wr  output  1  write request, level, held until ack
- rd  output  1  read request, level, held until ack
- rdat  input  DATA_W  read data, valid in the ack cycle
- ack  input  1  responder acknowledge, single-cycle
- busy  output  1  high from cs-fall detect until frame end and bus idle
- err  output  1  sticky read-underrun flag

Behaviour:
- Reset: one clock is used; reset is synchronous and active-high. In reset, miso=0, addr=0, wdat=0, wr=0, rd=0, busy=0, err=0, FSM=IDLE, bit counter=0.
- Reset mid-operation aborts everything immediately, including an outstanding wr/rd.
- Synchronisation: sclk, cs and mosi each pass through 2-flop synchronisers. Edges are detected on the synchronised value. Pin-to-detect latency is 3 clk.
- Timing requirement: sclk high and low phases are each at least 4 clk.
- Frame format, MSB first, sampled on sclk rising edges: rw bit (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits. Default frame length is 25 bits.
- FSM states and transitions:
  - IDLE → CMD on cs fall.
  - CMD: shift rw+addr. After the last address bit, go to WR_DATA if rw=1, else RD_REQ.
  - RD_REQ: assert rd with addr. On ack, capture rdat into the tx shift register and go to RD_DATA.
  - RD_DATA: on each detected sclk fall, miso ← tx MSB, then shift left by 1 and fill with 0. Go to DONE after DATA_W falls.
  - WR_DATA: shift DATA_W mosi bits into wdat. Then go to WR_REQ.
  - WR_REQ: assert wr. On ack go to DONE.
  - DONE: ignore further sclk edges; miso=0. Go to IDLE on cs rise.
- Bus handshake:
  - addr/wdat are stable whenever wr or rd is high.
  - wr and rd are never high together.
  - The request drops in the cycle after ack is sampled. Ack arriving in the same cycle the request rises is legal, giving a 1-cycle transaction.
  - Ack while idle is ignored.
- Read underrun:
  - The first data bit is driven on the sclk fall that follows the last address rise.
  - If ack has not arrived by that detected fall, set err (sticky until rst) and drive 0 for the whole data phase.
  - rd stays held until ack; late rdat is discarded.
- cs rise mid-frame (CMD, WR_DATA, RD_DATA):
  - Abort, reset the bit counter, miso=0, return to IDLE.
  - No write is issued for an incomplete write frame.
  - A request already asserted (rd) completes its handshake first; busy stays high until then.
- Over-long frames: bits after bit 25 are ignored and miso=0.
- cs high: miso=0. Sclk edges are ignored.
- A new cs fall while a request is still outstanding is held off: CMD starts only after the bus is idle.
- busy falls in the cycle after both cs high and no request are true.

Test Plan:
- Write: after reset, frame 1,0x5A,0xBEEF with 1-cycle ack → exactly one wr pulse window, addr=0x5A, wdat=0xBEEF, rd never high, err=0, busy low after cs rise.
- Read: frame 0,0x13 with responder rdat=0xA5C3 and ack 2 clk after rd → miso sampled on the next 16 rises = 0xA5C3, single rd handshake, err=0.
- Read underrun: ack delayed past the first data sclk fall → miso returns 0x0000, err=1 and stays 1 through the next good frame, rd drops after the late ack.
- Abort: cs rises after 5 address bits of a write, then a full write frame 1,0x22,0x1234 → only one wr, carrying addr=0x22 and wdat=0x1234.
- Back-to-back: read 0x01 then write 0x02/0x00FF with a minimal cs-high gap (4 clk) → both transactions correct and in order.
- Reset mid-frame: assert rst while rd is high → all outputs 0 the next cycle; the following write frame works normally.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 peripheral that converts rw/addr/data frames into register-bus
// read and write requests; the register block answers with a one-cycle ack.
module spi_reg_bridge #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdat,
  output logic              wr,
  output logic              rd,
  input  logic [DATA_W-1:0] rdat,
  input  logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RD_REQ, S_RD_DATA, S_WR_DATA, S_WR_REQ, S_DONE
  } state_t;

  state_t             r_state;
  logic               r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic               r_cs_meta, r_cs_sync, r_cs_prev;
  logic               r_mosi_meta, r_mosi_sync;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_rw;
  logic               r_cs_pend;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdat;
  logic [DATA_W-1:0]  r_tx;
  logic               r_miso, r_wr, r_rd, r_busy, r_err;

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_high, w_req;

  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
  assign w_cs_fall   = ~r_cs_sync & r_cs_prev;
  assign w_cs_high   = r_cs_sync;
  assign w_req       = r_wr | r_rd;

  // NOTE: all sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_cs_meta   <= 1'b0;
      r_cs_sync   <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_cs_pend   <= 1'b0;
      r_addr      <= '0;
      r_wdat      <= '0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sclk_meta <= sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_cs_meta   <= cs;
      r_cs_sync   <= r_cs_meta;
      r_cs_prev   <= r_cs_sync;
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;

      if (w_cs_fall)
        r_busy <= 1'b1;
      else if (w_cs_high && !w_req)
        r_busy <= 1'b0;

      // A request always drops the cycle after its ack, whatever the FSM is doing.
      if (ack && w_req) begin
        r_wr <= 1'b0;
        r_rd <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_miso    <= 1'b0;
          r_bit_cnt <= '0;
          if (w_cs_high) begin
            r_cs_pend <= 1'b0;
          end else if (w_cs_fall || r_cs_pend) begin
            if (w_req) begin
              r_cs_pend <= 1'b1;
            end else begin
              r_cs_pend <= 1'b0;
              r_state   <= S_CMD;
            end
          end
        end

        S_CMD: begin
          if (w_cs_high) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (w_sclk_rise) begin
            if (r_bit_cnt == '0)
              r_rw <= r_mosi_sync;
            else
              r_addr <= {r_addr[ADDR_W-2:0], r_mosi_sync};
            if (r_bit_cnt == ADDR_LAST) begin
              r_bit_cnt <= '0;
              if (r_rw) begin
                r_state <= S_WR_DATA;
              end else begin
                r_rd    <= 1'b1;
                r_state <= S_RD_REQ;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_WR_DATA: begin
          if (w_cs_high) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (w_sclk_rise) begin
            r_wdat <= {r_wdat[DATA_W-2:0], r_mosi_sync};
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              r_wr      <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_WR_REQ: begin
          if (ack)
            r_state <= S_DONE;
        end

        S_RD_REQ: begin
          if (w_cs_high) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (ack) begin
            r_state <= S_RD_DATA;
            if (w_sclk_fall) begin
              r_miso    <= rdat[DATA_W-1];
              r_tx      <= {rdat[DATA_W-2:0], 1'b0};
              r_bit_cnt <= CNT_W'(1);
            end else begin
              r_tx      <= rdat;
              r_bit_cnt <= '0;
            end
          end else if (w_sclk_fall) begin
            // Data was due on this fall but the responder has not answered:
            // flag it and shift out zeros; the late rdat is never captured.
            r_err     <= 1'b1;
            r_miso    <= 1'b0;
            r_tx      <= '0;
            r_bit_cnt <= CNT_W'(1);
            r_state   <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (w_cs_high) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_sclk_fall) begin
            if (r_bit_cnt == DATA_END) begin
              r_miso  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_miso    <= r_tx[DATA_W-1];
              r_tx      <= {r_tx[DATA_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_miso <= 1'b0;
          if (w_cs_high) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miso = r_miso;
  assign addr = r_addr;
  assign wdat = r_wdat;
  assign wr   = r_wr;
  assign rd   = r_rd;
  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: an SPI controller driver, a register
// responder with programmable ack latency, and queues of expected results.
module tb_spi_reg_bridge;

  localparam int H = 6;

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [15:0] wdat;
  } bus_txn_t;

  logic        clk = 1'b0;
  logic        rst, sclk, cs, mosi;
  logic        miso, wr, rd, ack, busy, err;
  logic [7:0]  addr;
  logic [15:0] wdat, rdat;

  bus_txn_t    bus_q[$];
  logic [15:0] rd_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = 0;
  logic [15:0] rd_value = '0;
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .addr(addr), .wdat(wdat), .wr(wr), .rd(rd), .rdat(rdat), .ack(ack),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 100 && busy; k++) wait_clks(1);
    check(tag, busy, 1'b0);
  endtask

  // Drives nbits of {rw, addr, data}; miso is sampled just before each data rise.
  task automatic spi_frame(input logic rw, input logic [7:0] a, input logic [15:0] d,
                           input int nbits, input bit end_frame, input int gap,
                           output logic [15:0] rx);
    logic [24:0] f;
    f  = {rw, a, d};
    rx = '0;
    cs = 1'b0;
    wait_clks(H);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[24-i];
      wait_clks(H);
      if (i >= 9) rx = {rx[14:0], miso};
      sclk = 1'b1;
      wait_clks(H);
      sclk = 1'b0;
    end
    if (end_frame) begin
      wait_clks(H);
      cs   = 1'b1;
      mosi = 1'b0;
      wait_clks(gap);
    end
  endtask

  // Register-file responder: acks ack_delay cycles after a request appears.
  initial begin
    int       wait_cnt;
    bus_txn_t exp;
    ack = 1'b0;
    rdat = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (ack) begin
        ack  = 1'b0;
        rdat = '0;
      end else if (rst || !(wr || rd)) begin
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        ack      = 1'b1;
        rdat     = rd_value;
        wait_cnt = 0;
        if (bus_q.size() == 0) begin
          check("unexpected_txn", 1, 0);
        end else begin
          exp = bus_q.pop_front();
          check("txn_kind", {31'd0, wr}, {31'd0, exp.is_wr});
          check("txn_addr", {24'd0, addr}, {24'd0, exp.addr});
          if (exp.is_wr) check("txn_wdat", {16'd0, wdat}, {16'd0, exp.wdat});
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  initial begin
    logic prev_wr, prev_rd;
    prev_wr = 1'b0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (wr && !prev_wr) wr_cnt++;
      if (rd && !prev_rd) rd_cnt++;
      if (wr && rd) both_cnt++;
      prev_wr = wr;
      prev_rd = rd;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rx;
    logic [15:0] exp_rx;
    int          wr0, rd0;

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clks(3);
    check("rst_miso", miso, 0);
    check("rst_addr", addr, 0);
    check("rst_wdat", wdat, 0);
    check("rst_wr",   wr,   0);
    check("rst_rd",   rd,   0);
    check("rst_busy", busy, 0);
    check("rst_err",  err,  0);
    rst = 1'b0;
    wait_clks(5);

    // Write with single-cycle ack
    ack_delay = 0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    bus_q.push_back('{is_wr: 1'b1, addr: 8'h5A, wdat: 16'hBEEF});
    spi_frame(1'b1, 8'h5A, 16'hBEEF, 25, 1'b1, 8, rx);
    wait_idle("wr_busy_low");
    check("wr_count", wr_cnt - wr0, 1);
    check("wr_no_rd", rd_cnt - rd0, 0);
    check("wr_err",   err, 0);

    // Read with ack two cycles after rd
    ack_delay = 2; rd_value = 16'hA5C3;
    rd0 = rd_cnt;
    bus_q.push_back('{is_wr: 1'b0, addr: 8'h13, wdat: 16'h0});
    rd_q.push_back(16'hA5C3);
    spi_frame(1'b0, 8'h13, 16'h0, 25, 1'b1, 8, rx);
    exp_rx = rd_q.pop_front();
    check("rd_data", rx, exp_rx);
    wait_idle("rd_busy_low");
    check("rd_count", rd_cnt - rd0, 1);
    check("rd_err",   err, 0);

    // Read underrun: ack lands after the first data fall
    ack_delay = 20; rd_value = 16'h5555;
    bus_q.push_back('{is_wr: 1'b0, addr: 8'h13, wdat: 16'h0});
    rd_q.push_back(16'h0000);
    spi_frame(1'b0, 8'h13, 16'h0, 25, 1'b1, 8, rx);
    exp_rx = rd_q.pop_front();
    check("urun_data", rx, exp_rx);
    wait_idle("urun_busy_low");
    check("urun_err",    err, 1);
    check("urun_rd_low", rd,  0);

    // A good read afterwards; err stays set
    ack_delay = 1; rd_value = 16'h0F0F;
    bus_q.push_back('{is_wr: 1'b0, addr: 8'h40, wdat: 16'h0});
    rd_q.push_back(16'h0F0F);
    spi_frame(1'b0, 8'h40, 16'h0, 25, 1'b1, 8, rx);
    exp_rx = rd_q.pop_front();
    check("post_urun_data", rx, exp_rx);
    wait_idle("post_urun_busy_low");
    check("err_sticky", err, 1);

    // Aborted write after 5 address bits, then a full write
    ack_delay = 0;
    wr0 = wr_cnt;
    spi_frame(1'b1, 8'h99, 16'hFFFF, 6, 1'b1, 8, rx);
    wait_idle("abort_busy_low");
    check("abort_no_wr", wr_cnt - wr0, 0);
    bus_q.push_back('{is_wr: 1'b1, addr: 8'h22, wdat: 16'h1234});
    spi_frame(1'b1, 8'h22, 16'h1234, 25, 1'b1, 8, rx);
    wait_idle("abort_wr_busy_low");
    check("abort_wr_count", wr_cnt - wr0, 1);
    check("abort_q_empty", bus_q.size(), 0);

    // Back-to-back read then write with a 4-clock cs-high gap
    ack_delay = 2; rd_value = 16'h7E81;
    wr0 = wr_cnt; rd0 = rd_cnt;
    bus_q.push_back('{is_wr: 1'b0, addr: 8'h01, wdat: 16'h0});
    rd_q.push_back(16'h7E81);
    spi_frame(1'b0, 8'h01, 16'h0, 25, 1'b1, 4, rx);
    exp_rx = rd_q.pop_front();
    check("b2b_rd_data", rx, exp_rx);
    bus_q.push_back('{is_wr: 1'b1, addr: 8'h02, wdat: 16'h00FF});
    spi_frame(1'b1, 8'h02, 16'h00FF, 25, 1'b1, 8, rx);
    wait_idle("b2b_busy_low");
    check("b2b_rd_count", rd_cnt - rd0, 1);
    check("b2b_wr_count", wr_cnt - wr0, 1);
    check("b2b_q_empty",  bus_q.size(), 0);

    // Reset while rd is outstanding
    ack_delay = 1000;
    bus_q.push_back('{is_wr: 1'b0, addr: 8'h44, wdat: 16'h0});
    spi_frame(1'b0, 8'h44, 16'h0, 9, 1'b0, 0, rx);
    for (int k = 0; k < 50 && !rd; k++) wait_clks(1);
    check("mid_rd_high",   rd,   1);
    check("mid_busy_high", busy, 1);
    rst = 1'b1;
    wait_clks(1);
    check("mid_rst_rd",   rd,   0);
    check("mid_rst_wr",   wr,   0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_wdat", wdat, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err",  err,  0);
    check("mid_rst_miso", miso, 0);
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    bus_q.delete();
    wait_clks(10);
    ack_delay = 0;
    wr0 = wr_cnt;
    bus_q.push_back('{is_wr: 1'b1, addr: 8'h3C, wdat: 16'hC0DE});
    spi_frame(1'b1, 8'h3C, 16'hC0DE, 25, 1'b1, 8, rx);
    wait_idle("post_rst_busy_low");
    check("post_rst_wr_count", wr_cnt - wr0, 1);
    check("post_rst_q_empty",  bus_q.size(), 0);
    check("post_rst_err",      err, 0);

    check("no_wr_rd_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
